// File: rtl/ahbl_arb_pkg.sv
// ahbl_arb_pkg: shared constants and types for the two-master AHB-Lite arbiter.
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - master index constants M1 (IFU) = 0, M2 (LSU) = 1
//   - hold_entry_t: address-phase attributes captured per master
//   - is_req(): true when an HTRANS value carries a transfer request
package ahbl_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  // Address width carried by a hold entry; the arbiter's AW must match.
  localparam int ARB_AW = 32;

  typedef struct packed {
    logic [ARB_AW-1:0] addr;
    logic [2:0]        size;
    logic              write;
  } hold_entry_t;

  // NONSEQ and SEQ both request a transfer; IDLE and BUSY do not.
  function automatic logic is_req(input logic [1:0] htrans);
    logic r;
    r = 1'b0;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: r = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahbl_arbiter_2m1s_if.sv
// ahbl_arbiter_2m1s_if: all bus-side signals of the 2-master/1-slave arbiter.
//   *_M1 / *_M2 : per-master AHB-Lite ports (IFU, LSU)
//   H*          : the shared AHB-Lite port toward the slave
// Modports:
//   master : arbiter view (it masters the shared bus and answers the cores)
//   slave  : environment view (cores and slave driving/observing the arbiter)
interface ahbl_arbiter_2m1s_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic [AW-1:0] HADDR_M1,  HADDR_M2;
  logic [1:0]    HTRANS_M1, HTRANS_M2;
  logic          HWRITE_M1, HWRITE_M2;
  logic [2:0]    HSIZE_M1,  HSIZE_M2;
  logic [DW-1:0] HWDATA_M1, HWDATA_M2;
  logic          HREADY_M1, HREADY_M2;
  logic [DW-1:0] HRDATA_M1, HRDATA_M2;

  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;

  modport master (
    input  HADDR_M1, HADDR_M2, HTRANS_M1, HTRANS_M2, HWRITE_M1, HWRITE_M2,
           HSIZE_M1, HSIZE_M2, HWDATA_M1, HWDATA_M2, HRDATA, HREADY,
    output HREADY_M1, HREADY_M2, HRDATA_M1, HRDATA_M2,
           HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );

  modport slave (
    output HADDR_M1, HADDR_M2, HTRANS_M1, HTRANS_M2, HWRITE_M1, HWRITE_M2,
           HSIZE_M1, HSIZE_M2, HWDATA_M1, HWDATA_M2, HRDATA, HREADY,
    input  HREADY_M1, HREADY_M2, HRDATA_M1, HRDATA_M2,
           HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );
endinterface

// File: rtl/ahbl_hold_reg.sv
// ahbl_hold_reg: one-entry address hold register for one master.
//   clk, rst : clock, synchronous active-high reset
//   cap      : capture din (master address phase accepted)
//   clr      : entry issued to the bus, drop it
//   din      : address-phase attributes from the master
//   hv_q     : entry valid (registered)
//   hv_d     : next-state valid, used by the arbiter to see same-edge captures
//   ent_q    : held entry
module ahbl_hold_reg
  import ahbl_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic        clr,
  input  hold_entry_t din,
  output logic        hv_q,
  output logic        hv_d,
  output hold_entry_t ent_q
);

  hold_entry_t ent_d;

  // cap and clr never coincide: a valid entry holds the master's HREADY
  // low, so it cannot be re-captured on the edge it is issued.
  always_comb begin
    hv_d  = hv_q;
    ent_d = ent_q;
    if (cap) begin
      hv_d  = 1'b1;
      ent_d = din;
    end else if (clr) begin
      hv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hv_q  <= 1'b0;
      ent_q <= '0;
    end else begin
      hv_q  <= hv_d;
      ent_q <= ent_d;
    end
  end

endmodule

// File: rtl/ahbl_arbiter_2m1s.sv
// ahbl_arbiter_2m1s: registered AHB-Lite arbiter sharing one slave port
// between the IFU (M1) and LSU (M2) masters.
// Ports:
//   HCLK   : clock
//   HRESET : synchronous active-high reset
//   bus    : ahbl_arbiter_2m1s_if.master (per-master ports + shared bus)
// Each master's address phase lands in its own hold register; held entries
// are issued one at a time into the bus address phase (aph), then tracked
// through the data phase (dph) so HREADY/HWDATA route to the right master.
// Build option:
//   AHB_ARB_RR_EN defined : round-robin on ties (last_grant register)
//   undefined             : fixed priority, M2 (LSU) wins ties
module ahbl_arbiter_2m1s
  import ahbl_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = 64
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahbl_arbiter_2m1s_if.master  bus
);

  hold_entry_t req_ent [2];
  hold_entry_t ent_q   [2];
  hold_entry_t aph_ent;
  logic [1:0]  req_vld;
  logic [1:0]  hv_q, hv_d;
  logic [1:0]  cap, clr;
  logic [1:0]  hready_m;

  logic aph_valid_q, aph_valid_d;
  logic aph_owner_q, aph_owner_d;
  logic dph_valid_q, dph_valid_d;
  logic dph_owner_q, dph_owner_d;
  logic tie_win;

  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;

  // ---------------------------------------------------------------------
  // Per-master capture / ready
  // ---------------------------------------------------------------------
  always_comb begin
    req_ent[M1] = '{addr: bus.HADDR_M1, size: bus.HSIZE_M1, write: bus.HWRITE_M1};
    req_ent[M2] = '{addr: bus.HADDR_M2, size: bus.HSIZE_M2, write: bus.HWRITE_M2};
    req_vld[M1] = is_req(bus.HTRANS_M1);
    req_vld[M2] = is_req(bus.HTRANS_M2);
    for (int i = 0; i < 2; i++) begin
      // A pending entry stalls its master; otherwise the master sees bus
      // HREADY only while its own transfer is in the bus data phase.
      hready_m[i] = 1'b1;
      if (hv_q[i]) begin
        hready_m[i] = 1'b0;
      end else if (dph_valid_q && (dph_owner_q == 1'(i))) begin
        hready_m[i] = bus.HREADY;
      end
      cap[i] = hready_m[i] & req_vld[i];
      clr[i] = bus.HREADY & aph_valid_q & (aph_owner_q == 1'(i));
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_hold
    ahbl_hold_reg u_hold (
      .clk   (HCLK),
      .rst   (HRESET),
      .cap   (cap[i]),
      .clr   (clr[i]),
      .din   (req_ent[i]),
      .hv_q  (hv_q[i]),
      .hv_d  (hv_d[i]),
      .ent_q (ent_q[i])
    );
  end

  // ---------------------------------------------------------------------
  // Tie-break policy
  // ---------------------------------------------------------------------
`ifdef AHB_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // The master not granted last wins a tie.
  assign tie_win = (last_grant_q == M2) ? M1 : M2;

  always_comb begin
    last_grant_d = last_grant_q;
    if (bus.HREADY && aph_valid_d) begin
      last_grant_d = aph_owner_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_grant_q <= M2;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign tie_win = M2;
`endif

  // ---------------------------------------------------------------------
  // Address / data phase pipeline; advances only when the bus is ready.
  // hv_d already has the issued entry cleared and same-edge captures set,
  // so it is exactly the candidate set for the next address phase.
  // ---------------------------------------------------------------------
  always_comb begin
    aph_valid_d = aph_valid_q;
    aph_owner_d = aph_owner_q;
    dph_valid_d = dph_valid_q;
    dph_owner_d = dph_owner_q;
    if (bus.HREADY) begin
      dph_valid_d = aph_valid_q;
      dph_owner_d = aph_owner_q;
      aph_valid_d = |hv_d;
      case (hv_d)
        2'b01:   aph_owner_d = M1;
        2'b10:   aph_owner_d = M2;
        2'b11:   aph_owner_d = tie_win;
        default: aph_owner_d = aph_owner_q;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aph_valid_q <= 1'b0;
      aph_owner_q <= M1;
      dph_valid_q <= 1'b0;
      dph_owner_q <= M1;
    end else begin
      aph_valid_q <= aph_valid_d;
      aph_owner_q <= aph_owner_d;
      dph_valid_q <= dph_valid_d;
      dph_owner_q <= dph_owner_d;
    end
  end

  // ---------------------------------------------------------------------
  // Shared bus outputs. Every issue is NONSEQ: no bursts are forwarded.
  // ---------------------------------------------------------------------
  assign aph_ent = ent_q[aph_owner_q];

  always_comb begin
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hsize  = '0;
    hwrite = 1'b0;
    if (aph_valid_q) begin
      htrans = HTRANS_NONSEQ;
      haddr  = aph_ent.addr;
      hsize  = aph_ent.size;
      hwrite = aph_ent.write;
    end
  end

  // The data-phase master keeps driving its write data until its own
  // HREADY rises, so HWDATA can be muxed straight from the master port.
  always_comb begin
    hwdata = '0;
    if (dph_valid_q) begin
      hwdata = (dph_owner_q == M2) ? bus.HWDATA_M2 : bus.HWDATA_M1;
    end
  end

  assign bus.HTRANS    = htrans;
  assign bus.HADDR     = haddr;
  assign bus.HSIZE     = hsize;
  assign bus.HWRITE    = hwrite;
  assign bus.HWDATA    = hwdata;
  assign bus.HREADY_M1 = hready_m[M1];
  assign bus.HREADY_M2 = hready_m[M2];
  assign bus.HRDATA_M1 = bus.HRDATA;
  assign bus.HRDATA_M2 = bus.HRDATA;

endmodule

// File: tb/tb_ahbl_arbiter_2m1s.sv
module tb_ahbl_arbiter_2m1s;
  import ahbl_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

`ifdef AHB_ARB_RR_EN
  localparam bit TIE_M1_FIRST = 1'b1;
`else
  localparam bit TIE_M1_FIRST = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESET;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
  } exp_t;
  exp_t exp_q[$];

  ahbl_arbiter_2m1s_if #(.AW(AW), .DW(DW)) bus ();

  ahbl_arbiter_2m1s #(.AW(AW), .DW(DW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.master)
  );

  always #5 HCLK = ~HCLK;

  // Scoreboard: every accepted bus address phase must match the next
  // expected transfer, in order.
  always @(negedge HCLK) begin
    if (!HRESET && bus.HTRANS == 2'b10 && bus.HREADY) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_spurious_issue got addr=%h exp none", bus.HADDR);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.HADDR !== e.addr || bus.HWRITE !== e.write) begin
          failures++;
          $display("FAIL sb_issue got addr=%h wr=%b exp addr=%h wr=%b",
                   bus.HADDR, bus.HWRITE, e.addr, e.write);
        end
      end
    end
  end

  task automatic push(input logic [AW-1:0] a, input logic w);
    exp_t e;
    e.addr  = a;
    e.write = w;
    exp_q.push_back(e);
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_masters();
    bus.HTRANS_M1 = 2'b00; bus.HADDR_M1 = '0; bus.HWRITE_M1 = 1'b0; bus.HSIZE_M1 = 3'd0;
    bus.HTRANS_M2 = 2'b00; bus.HADDR_M2 = '0; bus.HWRITE_M2 = 1'b0; bus.HSIZE_M2 = 3'd0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    idle_masters();
    bus.HREADY = 1'b1;
    next();
    next();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    bus.HWDATA_M1 = '0; bus.HWDATA_M2 = '0; bus.HRDATA = '0;
    do_reset();
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b1) begin failures++; $display("FAIL rst_hready_m1 got=%b exp=1", bus.HREADY_M1); end
    checks++; if (bus.HREADY_M2 !== 1'b1) begin failures++; $display("FAIL rst_hready_m2 got=%b exp=1", bus.HREADY_M2); end
    checks++; if (bus.HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%b exp=00", bus.HTRANS); end
    checks++; if (bus.HADDR !== '0) begin failures++; $display("FAIL rst_haddr got=%h exp=0", bus.HADDR); end
    checks++; if (bus.HWRITE !== 1'b0) begin failures++; $display("FAIL rst_hwrite got=%b exp=0", bus.HWRITE); end
    checks++; if (bus.HSIZE !== 3'd0) begin failures++; $display("FAIL rst_hsize got=%h exp=0", bus.HSIZE); end
    checks++; if (bus.HWDATA !== '0) begin failures++; $display("FAIL rst_hwdata got=%h exp=0", bus.HWDATA); end
    next();
  endtask

  task automatic test_single_read();
    // cycle 0: M1 drives NONSEQ
    bus.HTRANS_M1 = 2'b10; bus.HADDR_M1 = 32'h0000_1000; bus.HSIZE_M1 = 3'd3; bus.HWRITE_M1 = 1'b0;
    bus.HRDATA = 64'hDEAD_BEEF_0000_0001;
    push(32'h0000_1000, 1'b0);
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b1) begin failures++; $display("FAIL rd_cap_ready got=%b exp=1", bus.HREADY_M1); end
    next();
    // cycle 1: bus address phase
    bus.HTRANS_M1 = 2'b00;
    @(negedge HCLK);
    checks++; if (bus.HTRANS !== 2'b10) begin failures++; $display("FAIL rd_aph_htrans got=%b exp=10", bus.HTRANS); end
    checks++; if (bus.HADDR !== 32'h1000) begin failures++; $display("FAIL rd_aph_haddr got=%h exp=1000", bus.HADDR); end
    checks++; if (bus.HSIZE !== 3'd3) begin failures++; $display("FAIL rd_aph_hsize got=%h exp=3", bus.HSIZE); end
    checks++; if (bus.HREADY_M1 !== 1'b0) begin failures++; $display("FAIL rd_aph_ready got=%b exp=0", bus.HREADY_M1); end
    next();
    // cycle 2: data phase
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b1) begin failures++; $display("FAIL rd_dph_ready got=%b exp=1", bus.HREADY_M1); end
    checks++; if (bus.HRDATA_M1 !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL rd_dph_data got=%h exp=deadbeef00000001", bus.HRDATA_M1); end
    checks++; if (bus.HTRANS !== 2'b00) begin failures++; $display("FAIL rd_dph_htrans got=%b exp=00", bus.HTRANS); end
    next();
  endtask

  task automatic test_contention();
    logic [AW-1:0] fa, sa;
    logic rdy_f, rdy_s;
    do_reset();
    fa = TIE_M1_FIRST ? 32'h100 : 32'h200;
    sa = TIE_M1_FIRST ? 32'h200 : 32'h100;
    bus.HTRANS_M1 = 2'b10; bus.HADDR_M1 = 32'h100; bus.HWRITE_M1 = 1'b0;
    bus.HTRANS_M2 = 2'b10; bus.HADDR_M2 = 32'h200; bus.HWRITE_M2 = 1'b0;
    push(fa, 1'b0);
    push(sa, 1'b0);
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b1 || bus.HREADY_M2 !== 1'b1) begin failures++; $display("FAIL cont_cap_ready got=%b%b exp=11", bus.HREADY_M1, bus.HREADY_M2); end
    next();
    idle_masters();
    @(negedge HCLK);
    checks++; if (bus.HADDR !== fa || bus.HTRANS !== 2'b10) begin failures++; $display("FAIL cont_first got=%h/%b exp=%h/10", bus.HADDR, bus.HTRANS, fa); end
    checks++; if (bus.HREADY_M1 !== 1'b0 || bus.HREADY_M2 !== 1'b0) begin failures++; $display("FAIL cont_both_held got=%b%b exp=00", bus.HREADY_M1, bus.HREADY_M2); end
    next();
    @(negedge HCLK);
    rdy_f = TIE_M1_FIRST ? bus.HREADY_M1 : bus.HREADY_M2;
    rdy_s = TIE_M1_FIRST ? bus.HREADY_M2 : bus.HREADY_M1;
    checks++; if (bus.HADDR !== sa || bus.HTRANS !== 2'b10) begin failures++; $display("FAIL cont_second got=%h/%b exp=%h/10", bus.HADDR, bus.HTRANS, sa); end
    checks++; if (rdy_f !== 1'b1 || rdy_s !== 1'b0) begin failures++; $display("FAIL cont_ready_split got=%b%b exp=10", rdy_f, rdy_s); end
    next();
    @(negedge HCLK);
    rdy_s = TIE_M1_FIRST ? bus.HREADY_M2 : bus.HREADY_M1;
    checks++; if (bus.HTRANS !== 2'b00 || rdy_s !== 1'b1) begin failures++; $display("FAIL cont_done got=%b/%b exp=00/1", bus.HTRANS, rdy_s); end
    next();
  endtask

  task automatic test_wait_states();
    bus.HREADY = 1'b1;
    // cycle 0: M2 write request
    bus.HTRANS_M2 = 2'b10; bus.HADDR_M2 = 32'h300; bus.HWRITE_M2 = 1'b1; bus.HSIZE_M2 = 3'd1;
    push(32'h300, 1'b1);
    @(negedge HCLK);
    next();
    // cycle 1: M2 address phase; M2 supplies data, M1 requests
    bus.HTRANS_M2 = 2'b00; bus.HWDATA_M2 = 64'h55AA;
    bus.HTRANS_M1 = 2'b10; bus.HADDR_M1 = 32'h340; bus.HWRITE_M1 = 1'b0; bus.HWDATA_M1 = 64'h1111;
    push(32'h340, 1'b0);
    @(negedge HCLK);
    checks++; if (bus.HADDR !== 32'h300 || bus.HWRITE !== 1'b1 || bus.HSIZE !== 3'd1) begin failures++; $display("FAIL ws_aph got=%h/%b/%h exp=300/1/1", bus.HADDR, bus.HWRITE, bus.HSIZE); end
    checks++; if (bus.HREADY_M1 !== 1'b1) begin failures++; $display("FAIL ws_m1_cap got=%b exp=1", bus.HREADY_M1); end
    next();
    // cycles 2-4: three wait states, M1 address phase must hold
    bus.HTRANS_M1 = 2'b00;
    bus.HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      checks++; if (bus.HWDATA !== 64'h55AA) begin failures++; $display("FAIL ws_hwdata%0d got=%h exp=55aa", k, bus.HWDATA); end
      checks++; if (bus.HREADY_M2 !== 1'b0) begin failures++; $display("FAIL ws_ready_low%0d got=%b exp=0", k, bus.HREADY_M2); end
      checks++; if (bus.HADDR !== 32'h340 || bus.HTRANS !== 2'b10) begin failures++; $display("FAIL ws_aph_hold%0d got=%h/%b exp=340/10", k, bus.HADDR, bus.HTRANS); end
      next();
    end
    // cycle 5: data phase completes
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    checks++; if (bus.HWDATA !== 64'h55AA || bus.HREADY_M2 !== 1'b1) begin failures++; $display("FAIL ws_done got=%h/%b exp=55aa/1", bus.HWDATA, bus.HREADY_M2); end
    next();
    // cycle 6: M1 data phase; HWDATA now routed from M1
    bus.HWDATA_M2 = '0;
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b1 || bus.HWDATA !== 64'h1111) begin failures++; $display("FAIL ws_m1_dph got=%b/%h exp=1/1111", bus.HREADY_M1, bus.HWDATA); end
    next();
    bus.HWDATA_M1 = '0;
  endtask

  task automatic test_stall_capture();
    bus.HREADY = 1'b1;
    bus.HTRANS_M2 = 2'b10; bus.HADDR_M2 = 32'h400; bus.HWRITE_M2 = 1'b0;
    push(32'h400, 1'b0);
    @(negedge HCLK);
    next();
    bus.HTRANS_M2 = 2'b00;
    @(negedge HCLK);
    checks++; if (bus.HADDR !== 32'h400) begin failures++; $display("FAIL sc_aph got=%h exp=400", bus.HADDR); end
    next();
    // M2 data phase stalled; M1 requests
    bus.HREADY = 1'b0;
    bus.HTRANS_M1 = 2'b10; bus.HADDR_M1 = 32'h500; bus.HWRITE_M1 = 1'b0;
    push(32'h500, 1'b0);
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b1 || bus.HREADY_M2 !== 1'b0) begin failures++; $display("FAIL sc_cap got=%b%b exp=10", bus.HREADY_M1, bus.HREADY_M2); end
    next();
    bus.HTRANS_M1 = 2'b00;
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b0 || bus.HTRANS !== 2'b00) begin failures++; $display("FAIL sc_held got=%b/%b exp=0/00", bus.HREADY_M1, bus.HTRANS); end
    next();
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    checks++; if (bus.HTRANS !== 2'b00 || bus.HREADY_M2 !== 1'b1) begin failures++; $display("FAIL sc_release got=%b/%b exp=00/1", bus.HTRANS, bus.HREADY_M2); end
    next();
    @(negedge HCLK);
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h500) begin failures++; $display("FAIL sc_issue got=%b/%h exp=10/500", bus.HTRANS, bus.HADDR); end
    next();
    bus.HRDATA = 64'hCAFE;
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b1 || bus.HRDATA_M1 !== 64'hCAFE) begin failures++; $display("FAIL sc_dph got=%b/%h exp=1/cafe", bus.HREADY_M1, bus.HRDATA_M1); end
    next();
  endtask

  task automatic test_back_to_back();
    int n1 = 0, n2 = 0, issued = 0, cyc = 0;
    logic a1, a2, own, prev_own;
    do_reset();
    prev_own = 1'b0;
    while (issued < 16 && cyc < 200) begin
      bus.HTRANS_M1 = (n1 < 8) ? 2'b10 : 2'b00; bus.HADDR_M1 = 32'h1000 + 32'(n1 * 4);
      bus.HTRANS_M2 = (n2 < 8) ? 2'b10 : 2'b00; bus.HADDR_M2 = 32'h2000 + 32'(n2 * 4);
      @(negedge HCLK);
      a1 = (n1 < 8) && bus.HREADY_M1;
      a2 = (n2 < 8) && bus.HREADY_M2;
      if (a1 && a2) begin
        if (TIE_M1_FIRST) begin push(bus.HADDR_M1, 1'b0); push(bus.HADDR_M2, 1'b0); end
        else begin push(bus.HADDR_M2, 1'b0); push(bus.HADDR_M1, 1'b0); end
      end else if (a1) push(bus.HADDR_M1, 1'b0);
      else if (a2) push(bus.HADDR_M2, 1'b0);
      if (issued > 0) begin
        checks++; if (bus.HTRANS !== 2'b10) begin failures++; $display("FAIL b2b_gap%0d got=%b exp=10", issued, bus.HTRANS); end
      end
      if (bus.HTRANS == 2'b10 && bus.HREADY) begin
        own = bus.HADDR[13];
        if (issued > 0) begin
          checks++; if (own === prev_own) begin failures++; $display("FAIL b2b_alt%0d got=%b exp=%b", issued, own, !prev_own); end
        end
        prev_own = own;
        issued++;
      end
      if (a1) n1++;
      if (a2) n2++;
      next();
      cyc++;
    end
    checks++; if (issued != 16) begin failures++; $display("FAIL b2b_timeout got=%0d exp=16", issued); end
    idle_masters();
    next();
    next();
  endtask

  task automatic test_reset_mid();
    bus.HREADY = 1'b1;
    bus.HTRANS_M1 = 2'b10; bus.HADDR_M1 = 32'h600; bus.HWRITE_M1 = 1'b0;
    push(32'h600, 1'b0);
    @(negedge HCLK);
    next();
    bus.HTRANS_M1 = 2'b00;
    @(negedge HCLK);
    next();
    // M1 data phase, stalled, reset pulsed
    bus.HREADY = 1'b0;
    HRESET = 1'b1;
    @(negedge HCLK);
    checks++; if (bus.HREADY_M1 !== 1'b0) begin failures++; $display("FAIL rm_dph got=%b exp=0", bus.HREADY_M1); end
    next();
    HRESET = 1'b0;
    @(negedge HCLK);
    checks++; if (bus.HTRANS !== 2'b00) begin failures++; $display("FAIL rm_htrans got=%b exp=00", bus.HTRANS); end
    checks++; if (bus.HREADY_M1 !== 1'b1 || bus.HREADY_M2 !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b%b exp=11", bus.HREADY_M1, bus.HREADY_M2); end
    next();
    bus.HREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      checks++; if (bus.HTRANS !== 2'b00) begin failures++; $display("FAIL rm_quiet%0d got=%b exp=00", k, bus.HTRANS); end
      next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    idle_masters();
    bus.HREADY = 1'b1;
    test_reset();
    test_single_read();
    test_contention();
    test_wait_states();
    test_stall_capture();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
